// File: rtl/board_if.sv
// Bus bundle between the board store, the game controller and the pixel renderer.
// With BOARD_HIGHLIGHT_EN defined the bundle also carries sel_addr.
interface board_if;
    logic [5:0] addr;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       clr_valid;
    logic [5:0] clr_a;
    logic [5:0] clr_b;
    logic       clr_ok;
    logic       clr_err;
    logic [5:0] remaining;
`ifdef BOARD_HIGHLIGHT_EN
    logic [5:0] sel_addr;

    modport master (output addr, clr_valid, clr_a, clr_b, sel_addr,
                    input  r, g, b, clr_ok, clr_err, remaining);
    modport slave  (input  addr, clr_valid, clr_a, clr_b, sel_addr,
                    output r, g, b, clr_ok, clr_err, remaining);
`else
    modport master (output addr, clr_valid, clr_a, clr_b,
                    input  r, g, b, clr_ok, clr_err, remaining);
    modport slave  (input  addr, clr_valid, clr_a, clr_b,
                    output r, g, b, clr_ok, clr_err, remaining);
`endif
endinterface

// File: rtl/board.sv
// 6x6 tile-state store with registered colour lookup and matched-pair removal.
// Optional BOARD_HIGHLIGHT_EN inverts the colour of the selected non-empty cell.
module board (
    input  logic    clk,
    input  logic    rst_n,
    board_if.slave  bus
);
    localparam int unsigned CELLS = 36;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned AW    = 6;
    localparam int unsigned COL_W = 8;

    logic [ID_W-1:0]  r_cells [CELLS];
    logic [COL_W-1:0] r_col;
    logic             r_ok;
    logic             r_err;
    logic [AW-1:0]    r_remaining;

    logic [ID_W-1:0]  w_rd_id;
    logic [ID_W-1:0]  w_id_a;
    logic [ID_W-1:0]  w_id_b;
    logic [COL_W-1:0] w_col;
    logic             w_acc;

    // Packed {r[2:0], g[2:0], b[1:0]} palette.
    function automatic logic [COL_W-1:0] palette(input logic [ID_W-1:0] id);
        case (id)
            3'd1:    palette = {3'd7, 3'd0, 2'd0};
            3'd2:    palette = {3'd0, 3'd7, 2'd0};
            3'd3:    palette = {3'd0, 3'd0, 2'd3};
            3'd4:    palette = {3'd7, 3'd7, 2'd0};
            3'd5:    palette = {3'd7, 3'd0, 2'd3};
            3'd6:    palette = {3'd0, 3'd7, 2'd3};
            3'd7:    palette = {3'd7, 3'd7, 2'd3};
            default: palette = '0;
        endcase
    endfunction

    // Lookups read the pre-update array, giving read-before-write on collisions.
    always_comb begin
        w_rd_id = '0;
        w_id_a  = '0;
        w_id_b  = '0;
        if (bus.addr  < AW'(CELLS)) w_rd_id = r_cells[bus.addr];
        if (bus.clr_a < AW'(CELLS)) w_id_a  = r_cells[bus.clr_a];
        if (bus.clr_b < AW'(CELLS)) w_id_b  = r_cells[bus.clr_b];
        w_acc = bus.clr_valid && (bus.clr_a < AW'(CELLS)) && (bus.clr_b < AW'(CELLS)) &&
                (bus.clr_a != bus.clr_b) && (w_id_a != '0) && (w_id_a == w_id_b);
        w_col = palette(w_rd_id);
`ifdef BOARD_HIGHLIGHT_EN
        if ((bus.addr == bus.sel_addr) && (w_rd_id != '0)) w_col = ~w_col;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < int'(CELLS); a++)
                r_cells[a] <= ID_W'(((a / 2) % 6) + 1);
            r_col       <= '0;
            r_ok        <= 1'b0;
            r_err       <= 1'b0;
            r_remaining <= AW'(CELLS);
        end else begin
            r_col <= w_col;
            r_ok  <= w_acc;
            r_err <= bus.clr_valid && !w_acc;
            if (w_acc) begin
                r_cells[bus.clr_a] <= '0;
                r_cells[bus.clr_b] <= '0;
                r_remaining        <= r_remaining - AW'(2);
            end
        end
    end

    assign bus.r         = r_col[7:5];
    assign bus.g         = r_col[4:2];
    assign bus.b         = r_col[1:0];
    assign bus.clr_ok    = r_ok;
    assign bus.clr_err   = r_err;
    assign bus.remaining = r_remaining;
endmodule

// File: tb/tb_board.sv
// Scoreboard bench for board: driver pushes model expectations, monitor pops and compares.
module tb_board;
    typedef struct {
        int r;
        int g;
        int b;
        int ok;
        int err;
        int rem;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    board_if bif ();

    board dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    int m_cells [36];
    int pal_r [8] = '{0, 7, 0, 0, 7, 7, 0, 7};
    int pal_g [8] = '{0, 0, 7, 0, 7, 0, 7, 7};
    int pal_b [8] = '{0, 0, 0, 3, 0, 3, 3, 3};
`ifdef BOARD_HIGHLIGHT_EN
    int sel = 63;
`endif

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Initial board: pairs of equal IDs, IDs 1..6 cycling every 12 cells.
    task automatic model_reset();
        for (int a = 0; a < 36; a++) m_cells[a] = ((a / 2) % 6) + 1;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int a = 0; a < 36; a++) if (m_cells[a] != 0) n++;
        return n;
    endfunction

    task automatic drive(input int a, input bit cv, input int ca, input int cb);
        exp_t e;
        int id;
        @(negedge clk);
        bif.addr      = 6'(a);
        bif.clr_valid = cv;
        bif.clr_a     = 6'(ca);
        bif.clr_b     = 6'(cb);
`ifdef BOARD_HIGHLIGHT_EN
        bif.sel_addr  = 6'(sel);
`endif
        id = (a < 36) ? m_cells[a] : 0;
        e.r = pal_r[id];
        e.g = pal_g[id];
        e.b = pal_b[id];
`ifdef BOARD_HIGHLIGHT_EN
        if (a == sel && id != 0) begin
            e.r = 7 - e.r;
            e.g = 7 - e.g;
            e.b = 3 - e.b;
        end
`endif
        e.ok  = 0;
        e.err = 0;
        if (cv) begin
            if (ca < 36 && cb < 36 && ca != cb && m_cells[ca] != 0 && m_cells[ca] == m_cells[cb]) begin
                m_cells[ca] = 0;
                m_cells[cb] = 0;
                e.ok = 1;
            end else begin
                e.err = 1;
            end
        end
        e.rem = model_count();
        q.push_back(e);
    endtask

    task automatic chk_reset_vals();
        chk("rst_r", int'(bif.r), 0);
        chk("rst_g", int'(bif.g), 0);
        chk("rst_b", int'(bif.b), 0);
        chk("rst_ok", int'(bif.clr_ok), 0);
        chk("rst_err", int'(bif.clr_err), 0);
        chk("rst_remaining", int'(bif.remaining), 36);
    endtask

    // Reset asserted asynchronously while a valid clear is being presented.
    task automatic reset_mid(input int ca, input int cb);
        @(negedge clk);
        bif.clr_valid = 1'b1;
        bif.clr_a     = 6'(ca);
        bif.clr_b     = 6'(cb);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bif.clr_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: outputs are presented every cycle, compared 2 time units after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("colour_r", int'(bif.r), e.r);
                chk("colour_g", int'(bif.g), e.g);
                chk("colour_b", int'(bif.b), e.b);
                chk("clr_ok", int'(bif.clr_ok), e.ok);
                chk("clr_err", int'(bif.clr_err), e.err);
                chk("remaining", int'(bif.remaining), e.rem);
            end
        end
    end

    initial begin
        int ca, cb;
        bif.addr      = '0;
        bif.clr_valid = 1'b0;
        bif.clr_a     = '0;
        bif.clr_b     = '0;
`ifdef BOARD_HIGHLIGHT_EN
        bif.sel_addr  = 6'(sel);
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 36; a++) drive(a, 1'b0, 0, 0);
        drive(40, 1'b0, 0, 0);
        drive(63, 1'b0, 0, 0);
        drive(0, 1'b1, 0, 1);
        drive(0, 1'b0, 0, 0);
        drive(2, 1'b1, 2, 4);
        drive(2, 1'b1, 0, 1);
        drive(6, 1'b1, 6, 6);
        drive(36, 1'b1, 36, 37);
        drive(3, 1'b1, 2, 3);
        drive(3, 1'b0, 0, 0);

`ifdef BOARD_HIGHLIGHT_EN
        reset_mid(4, 5);
        sel = 0;
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        drive(0, 1'b1, 0, 1);
        drive(0, 1'b0, 0, 0);
`endif

        reset_mid(8, 9);
        for (int i = 0; i < 400; i++) begin
            ca = $urandom_range(0, 39);
            cb = ($urandom_range(0, 1) == 1) ? (ca ^ 1) : int'($urandom_range(0, 39));
            if ($urandom_range(0, 7) == 0) cb = ca;
`ifdef BOARD_HIGHLIGHT_EN
            sel = $urandom_range(0, 40);
`endif
            drive($urandom_range(0, 47), 1'($urandom_range(0, 1)), ca, cb);
        end

        reset_mid(0, 1);
        for (int k = 0; k < 18; k++) drive(2 * k, 1'b1, 2 * k, 2 * k + 1);
        for (int a = 0; a < 36; a++) drive(a, 1'b0, 0, 0);
        drive(0, 1'b1, 0, 1);
        reset_mid(10, 11);
        drive(0, 1'b0, 0, 0);
        drive(35, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        #3 chk("scoreboard_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/board.md
Name: board

Overview:
- Tile-state store and colour lookup for a 6x6 matching-game board (36 cells, linear address = row*6 + col).
- The display/VGA path presents a cell address and receives that cell's 8-bit RGB (3-3-2) colour one clock later.
- The game-logic path removes matched pairs and reads the remaining-tile count.
- Sits between the game controller and the pixel renderer.

Parameters:
- CELLS, 36, number of valid cells (addresses 0..CELLS-1); fixed 6x6 layout.
- ID_W, 3, tile-ID width; ID 0 = empty, 1..7 = tile types.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- addr  input  6  read address for colour lookup
- r  output  3  red component of cell at registered addr
- g  output  3  green component
- b  output  2  blue component
- clr_valid  input  1  request removal of pair (clr_a, clr_b), single-cycle strobe
- clr_a  input  6  first cell of pair
- clr_b  input  6  second cell of pair
- clr_ok  output  1  one-cycle pulse: pair removed
- clr_err  output  1  one-cycle pulse: request rejected
- remaining  output  6  count of non-empty cells

Behaviour:
- Reset (async, rst_n=0):
  - Cell a loads ID ((a/2) mod 6)+1, integer division: cells 0,1 = 1; 2,3 = 2; ... 10,11 = 6; pattern repeats every 12. Each ID 1..6 occurs 6 times; ID 7 unused initially.
  - r/g/b = 0; clr_ok = clr_err = 0; remaining = 36.
- Reset asserted mid-operation aborts any pending clear and restores the initial pattern.
- Colour read:
  - r/g/b registered; addr sampled at edge N, colour valid after edge N (latency 1).
  - Palette ID->{r,g,b}: 0->{0,0,0}, 1->{7,0,0}, 2->{0,7,0}, 3->{0,0,3}, 4->{7,7,0}, 5->{7,0,3}, 6->{0,7,3}, 7->{7,7,3}.
  - addr >= 36 -> {0,0,0}.
- Clear (evaluated on edge where clr_valid=1):
  - Accept iff clr_a<36, clr_b<36, clr_a!=clr_b, both IDs non-zero and equal.
  - Accept: both cells set to 0, remaining decremented by 2, clr_ok=1 for exactly the following cycle.
  - Otherwise: no state change, clr_err=1 for the following cycle.
  - clr_ok and clr_err never both 1; both 0 when clr_valid=0.
- Read/clear collision: read of a cell cleared on the same edge returns the pre-clear colour (read-before-write); the next read returns black.
- remaining never underflows; reaches 0 only when all cells are empty; stays 0 thereafter until reset.
- No handshake back-pressure; a clear may be issued every cycle.

Optional Feature:
- Macro BOARD_HIGHLIGHT_EN.
- Defined: adds input sel_addr (6 bits). When registered addr equals sel_addr and the cell is non-empty, output colour is bitwise-inverted palette colour (e.g. ID1 -> {0,7,3}); empty cells stay black.
- Undefined: port absent, colours exactly per palette.

Test Plan:
- Reset then sweep addr 0..35, one per clock -> addr0 {7,0,0}, addr2 {0,7,0}, addr4 {0,0,3}, addr12 {7,0,0}, addr35 {0,7,3}, each one cycle after addr applied; remaining=36.
- addr=40 -> {0,0,0} next cycle.
- clr_valid, clr_a=0, clr_b=1 -> clr_ok pulse, remaining=34; read addr0 -> {0,0,0}.
- clr_a=2, clr_b=4 (IDs 2 vs 3) -> clr_err pulse, remaining unchanged; repeat clear 0/1 (already empty) -> clr_err; clr_a=clr_b=6 -> clr_err.
- Clear all 18 valid pairs back-to-back -> 18 clr_ok pulses, remaining=0, all reads black; then assert rst_n=0 asynchronously mid-clear -> remaining=36, addr0 red.
- With BOARD_HIGHLIGHT_EN: sel_addr=0, addr=0 -> {0,7,3}; addr=1 -> {7,0,0}.
